// File: rtl/hall_input_filter.sv
// Hall sensor input conditioning: two-flop synchroniser, glitch filter, illegal-code and skip detection.
// Optional stall detection is enabled by defining HALL_FILTER_STALL_DETECT_EN.

package hall_input_filter_pkg;
    typedef logic [2:0] hall_states_t;
endpackage

module hall_input_filter
    import hall_input_filter_pkg::*;
#(
    parameter int unsigned clk_freq_hz   = 54_000_000,
    parameter int unsigned filter_cycles = 16,
    parameter int unsigned stall_cycles  = clk_freq_hz / 10
) (
    input  logic         sys_clk,
    input  logic         reset,
    input  logic [2:0]   hall_raw,
    output hall_states_t hall_values,
    output logic         hall_changed,
    output logic         hall_error,
    output logic         hall_skip,
    output logic         hall_stall
);

    localparam int unsigned cnt_w = $clog2(filter_cycles) + 1;
    localparam logic [cnt_w-1:0] cnt_max = cnt_w'(filter_cycles - 1);

    function automatic logic code_valid(input logic [2:0] code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    function automatic logic [1:0] popcount3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    logic [2:0]       s1_r;
    logic [2:0]       s2_r;
    logic [2:0]       candidate_r;
    logic [cnt_w-1:0] stable_cnt_r;
    logic             primed_r;
    logic [cnt_w-1:0] cnt_inc_s;
    logic             commit_s;
    logic             skip_s;

    // Commit decision: a stable candidate commits when its count reaches the threshold on this edge.
    always_comb begin
        cnt_inc_s = stable_cnt_r;
        commit_s  = 1'b0;
        skip_s    = 1'b0;
        if (stable_cnt_r != cnt_max) begin
            cnt_inc_s = stable_cnt_r + cnt_w'(1);
        end else begin
            cnt_inc_s = stable_cnt_r;
        end
        if (s2_r == candidate_r) begin
            commit_s = (cnt_inc_s == cnt_max) && ((candidate_r != hall_values) || !primed_r);
        end else begin
            commit_s = 1'b0;
        end
        skip_s = primed_r && code_valid(hall_values) && code_valid(candidate_r)
                 && (popcount3(hall_values ^ candidate_r) > 2'd1);
    end

    // Synchroniser, filter state and committed outputs.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            s1_r         <= 3'b000;
            s2_r         <= 3'b000;
            candidate_r  <= 3'b000;
            stable_cnt_r <= {cnt_w{1'b0}};
            primed_r     <= 1'b0;
            hall_values  <= 3'b000;
            hall_changed <= 1'b0;
            hall_error   <= 1'b0;
            hall_skip    <= 1'b0;
        end else begin
            s1_r         <= hall_raw;
            s2_r         <= s1_r;
            hall_changed <= 1'b0;
            hall_skip    <= 1'b0;
            // A fresh input level always restarts filtering, even on an edge that would have committed.
            if (s2_r != candidate_r) begin
                candidate_r  <= s2_r;
                stable_cnt_r <= {cnt_w{1'b0}};
            end else begin
                stable_cnt_r <= cnt_inc_s;
                if (commit_s) begin
                    hall_values  <= candidate_r;
                    primed_r     <= 1'b1;
                    hall_changed <= 1'b1;
                    hall_error   <= !code_valid(candidate_r);
                    hall_skip    <= skip_s;
                end
            end
        end
    end

`ifdef HALL_FILTER_STALL_DETECT_EN
    localparam int unsigned stall_w = $clog2(stall_cycles + 1);
    localparam logic [stall_w-1:0] stall_max = stall_w'(stall_cycles);

    logic [stall_w-1:0] stall_cnt_r;
    logic [stall_w-1:0] stall_inc_s;

    // Saturating increment of the time-since-commit counter.
    always_comb begin
        stall_inc_s = stall_cnt_r;
        if (stall_cnt_r != stall_max) begin
            stall_inc_s = stall_cnt_r + stall_w'(1);
        end else begin
            stall_inc_s = stall_cnt_r;
        end
    end

    // Stall counter and flag; every commit restarts the count.
    always_ff @(posedge sys_clk) begin
        if (reset || ((s2_r == candidate_r) && commit_s)) begin
            stall_cnt_r <= {stall_w{1'b0}};
            hall_stall  <= 1'b0;
        end else if (primed_r) begin
            stall_cnt_r <= stall_inc_s;
            hall_stall  <= (stall_inc_s == stall_max);
        end
    end
`else
    assign hall_stall = 1'b0;
`endif

endmodule

// File: tb/tb_hall_input_filter.sv
// Self-checking bench for hall_input_filter: table-driven code sequences scored against a commit queue.
`timescale 1ns/1ps

module tb_hall_input_filter;

    localparam int unsigned filter_cycles = 4;
    localparam int unsigned stall_cycles  = 100;
    localparam int unsigned latency       = filter_cycles + 1;

    logic       sys_clk;
    logic       reset;
    logic [2:0] hall_raw;
    logic [2:0] hall_values;
    logic       hall_changed;
    logic       hall_error;
    logic       hall_skip;
    logic       hall_stall;

    hall_input_filter #(
        .filter_cycles (filter_cycles),
        .stall_cycles  (stall_cycles)
    ) dut (
        .sys_clk      (sys_clk),
        .reset        (reset),
        .hall_raw     (hall_raw),
        .hall_values  (hall_values),
        .hall_changed (hall_changed),
        .hall_error   (hall_error),
        .hall_skip    (hall_skip),
        .hall_stall   (hall_stall)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [2:0] code;
        int         hold;
        bit         commit;
        bit         skip;
        bit         err;
    } vec_t;

    typedef struct {
        int         due;
        logic [2:0] code;
        bit         skip;
        bit         err;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   edge_cnt = 0;
    int   last_commit_edge = 0;
    bit   mon_en = 1'b0;
    bit   exp_err_lvl = 1'b0;

    always @(posedge sys_clk) edge_cnt++;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, req);
        end
    endtask

    // Scoreboard: every commit must match the queue head on exactly its due edge.
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (hall_changed) begin
                if (q.size() == 0) begin
                    check("unexpected_changed", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("commit_edge", edge_cnt, e.due);
                    check("hall_values", int'(hall_values), int'(e.code));
                    check("hall_skip", int'(hall_skip), int'(e.skip));
                    exp_err_lvl = e.err;
                    last_commit_edge = edge_cnt;
                end
            end else begin
                check("skip_without_commit", int'(hall_skip), 0);
                if (q.size() != 0 && edge_cnt > q[0].due) begin
                    check("missed_commit", edge_cnt, q[0].due);
                    void'(q.pop_front());
                end
            end
            check("hall_error", int'(hall_error), int'(exp_err_lvl));
`ifndef HALL_FILTER_STALL_DETECT_EN
            check("hall_stall_off", int'(hall_stall), 0);
`endif
        end
    end

    task automatic drive(input logic [2:0] code, input int hold, input bit commit,
                         input bit skip, input bit err);
        exp_t e;
        hall_raw = code;
        if (commit) begin
            e.due  = edge_cnt + 1 + latency;
            e.code = code;
            e.skip = skip;
            e.err  = err;
            q.push_back(e);
        end
        repeat (hold) @(negedge sys_clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_values"},  int'(hall_values),  0);
        check({tag, "_changed"}, int'(hall_changed), 0);
        check({tag, "_error"},   int'(hall_error),   0);
        check({tag, "_skip"},    int'(hall_skip),    0);
        check({tag, "_stall"},   int'(hall_stall),   0);
    endtask

    vec_t vecs[17];
    int   due;
    int   waited;

    initial begin
        vecs[0]  = '{3'b001,  8, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b011,  3, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{3'b001,  8, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'b011,  4, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 10, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b011, 10, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b010, 10, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'b110, 10, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b100, 10, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{3'b101, 10, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{3'b001, 10, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{3'b110, 10, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{3'b111, 10, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{3'b101, 10, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{3'b010, 10, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{3'b000, 10, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{3'b011, 10, 1'b1, 1'b0, 1'b0};

        reset    = 1'b1;
        hall_raw = 3'b000;
        repeat (3) @(negedge sys_clk);
        check_reset_outputs("reset");

        reset  = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].code, vecs[i].hold, vecs[i].commit, vecs[i].skip, vecs[i].err);
        end
        repeat (8) @(negedge sys_clk);
        check("queue_drained_table", q.size(), 0);

        // Reset two edges into filtering a new code discards it.
        drive(3'b101, 2, 1'b0, 1'b0, 1'b0);
        mon_en = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge sys_clk);
        check_reset_outputs("midreset");
        q.delete();
        exp_err_lvl = 1'b0;
        reset  = 1'b0;
        mon_en = 1'b1;
        drive(3'b100, 8, 1'b1, 1'b0, 1'b0);
        check("first_commit_after_reset", int'(hall_values), 3'b100);

        // Hold the code and look for the stall flag.
        waited = 0;
        while (!hall_stall && waited < 150) begin
            @(negedge sys_clk);
            waited++;
        end
`ifdef HALL_FILTER_STALL_DETECT_EN
        check("stall_rise", int'(hall_stall), 1);
        check("stall_rise_edge", edge_cnt, last_commit_edge + int'(stall_cycles));
`else
        check("stall_absent", int'(hall_stall), 0);
`endif

        hall_raw = 3'b101;
        due = edge_cnt + 1 + latency;
        q.push_back('{due, 3'b101, 1'b0, 1'b0});
        while (edge_cnt < due - 1) @(negedge sys_clk);
`ifdef HALL_FILTER_STALL_DETECT_EN
        check("stall_before_commit", int'(hall_stall), 1);
`endif
        @(negedge sys_clk);
        check("stall_on_commit", int'(hall_stall), 0);
        check("changed_on_commit", int'(hall_changed), 1);
        repeat (6) @(negedge sys_clk);
        check("queue_drained_final", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hall_input_filter.md
# hall_input_filter

Conditions the three raw Hall sensor inputs before they reach the BLDC driver peripheral's `hall_values` port.
- Synchronises the asynchronous pins to `sys_clk`.
- Rejects glitches shorter than a programmable number of cycles.
- Flags illegal codes (000/111) and skipped sectors.
- Optionally flags a stalled rotor.

Sits between the board pins and the BLDC peripheral, in the `sys_clk` domain.

## Interface
Parameters:
- `clk_freq_hz`, 54_000_000, `sys_clk` frequency; used only for `stall_cycles` default.
- `filter_cycles`, 16, consecutive sampling edges a level must hold to be accepted; legal range ≥ 2.
- `stall_cycles`, `clk_freq_hz/10`, cycles without a commit before stall is flagged.

Ports (one clock; reset is synchronous and active-high):
- `sys_clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `hall_raw` input 3: raw Hall pins {A,B,C}, asynchronous.
- `hall_values` output 3: filtered Hall code {A,B,C}, type `hall_states_t`.
- `hall_changed` output 1: one-cycle pulse on every commit.
- `hall_error` output 1: level; committed code is 3'b000 or 3'b111.
- `hall_skip` output 1: one-cycle pulse; a valid→valid commit changed more than one bit.
- `hall_stall` output 1: level; no commit for `stall_cycles`.

## Operation
- Synchroniser: two flops, `s1 <= hall_raw`, `s2 <= s1`. Only `s2` is used downstream.
- Filter state: `candidate` (3 bits), `stable_cnt` (width `$clog2(filter_cycles)+1`), `primed` flag.
- Each edge, when `s2 != candidate`: `candidate <= s2` and `stable_cnt <= 0`.
- Each edge, when `s2 == candidate`:
  - `stable_cnt` increments, saturating at `filter_cycles-1`.
  - If `stable_cnt == filter_cycles-1` and (`candidate != hall_values` or `!primed`), commit.
- Commit actions (all on the same edge):
  - `hall_values <= candidate`, `primed <= 1`.
  - `hall_changed` pulses.
  - `hall_error <= (candidate==3'b000 || candidate==3'b111)`.
  - `hall_skip` pulses when `primed`, the old code is valid, the new code is valid, and popcount(old^new) > 1.
- Legal sequence: 001, 011, 010, 110, 100, 101. Adjacent codes differ in one bit.
- `hall_error` holds until the next commit of a valid code.
- No commit occurs while the input stays equal to `hall_values`, so `hall_changed` does not repeat for an unchanged code.
- Reset values:
  - Outputs: `hall_values`=3'b000, `hall_changed`=0, `hall_error`=0, `hall_skip`=0, `hall_stall`=0.
  - Internal: `s1`=`s2`=`candidate`=0, `stable_cnt`=0, `primed`=0.
- Reset asserted mid-filtering discards the candidate and counter. The first stable level after reset always commits, including 3'b000.

## Timing
- Let edge k be the first sampling edge of a new level.
- If the level holds for ≥ `filter_cycles` sampling edges, `hall_values` and `hall_changed` update at edge k+`filter_cycles`+1.
- A level held for `filter_cycles-1` edges or fewer is never committed.
- Glitch back to the committed code before commit: `candidate` reverts and there is no output activity.
- Simultaneous events:
  - A new input change on the same edge that would commit blocks the commit. The `s2 != candidate` branch has priority.
  - Reset has priority over everything.
- `hall_error`, `hall_skip` and `hall_changed` all update on the commit edge. There is no extra latency.

## Configuration
- Macro: `HALL_FILTER_STALL_DETECT_EN`.
- Defined:
  - A stall counter of width `$clog2(stall_cycles+1)` clears on reset and on every commit.
  - Once `primed`, the counter increments and saturates at `stall_cycles`.
  - `hall_stall` = (counter == `stall_cycles`). It deasserts on the edge of the next commit.
- Undefined: the counter is not instantiated and `hall_stall` is tied to 0.

## Test plan
- Reset release with `hall_raw`=001 steady, `filter_cycles`=4:
  - `hall_values`=001 and a single `hall_changed` pulse 5 edges after the first sampling edge.
  - `hall_error`=0.
- Committed 001, then `hall_raw`=011 for 3 edges, then back to 001: no `hall_changed`, `hall_values` stays 001. Repeat with 4 edges held: commit to 011.
- Sequence 001→011→010→110→100→101→001, each held 10 edges: six `hall_changed` pulses, no `hall_skip`, no `hall_error`.
- 001→110 held stable: `hall_skip` one-cycle pulse on the commit edge, `hall_values`=110. Then 111 held stable: `hall_error`=1, no `hall_skip`.
- Reset asserted 2 edges into filtering a new code: all outputs return to reset values, and the next stable code commits as the first commit.
- With `HALL_FILTER_STALL_DETECT_EN` and `stall_cycles`=100: hold 001 after commit, and `hall_stall` rises exactly 100 edges after the commit edge. Change to 011 and `hall_stall` falls on that commit edge. Without the macro, `hall_stall` stays 0 throughout.
